// File: rtl/display_page_sequencer.sv
// Captures a 128-bit AES block for the hex display and selects which 32-bit page is shown,
// stepping on debounced next/prev buttons or an optional auto-scroll timer.
module display_page_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned AUTO_CYCLES     = 200_000_000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         aes_valid_i,
    input  logic [127:0] aes_data_i,
    output logic         aes_ready_o,
    input  logic         hold_i,
    input  logic         btn_next_i,
    input  logic         btn_prev_i,
    input  logic         auto_en_i,
    output logic [127:0] disp_data_o,
    output logic [2:0]   digit_sel_o,
    output logic [3:0]   page_led_o,
    output logic         new_flag_o
);

    localparam int unsigned DbW   = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned AutoW = $clog2(AUTO_CYCLES);
    localparam logic [DbW-1:0]   DbMax   = DbW'(DEBOUNCE_CYCLES - 1);
    localparam logic [AutoW-1:0] AutoMax = AutoW'(AUTO_CYCLES - 1);

    // Index 0 is the next button, index 1 the prev button.
    logic [1:0]     btn_raw;
    logic [1:0]     sync1_q, sync2_q;
    logic [1:0]     stable_q, stable_d, stable_dly_q;
    logic [1:0]     pulse_q;
    logic [DbW-1:0] cnt_q [2];
    logic [DbW-1:0] cnt_d [2];

    logic [127:0]     data_q, data_d;
    logic [1:0]       page_q, page_d;
    logic [AutoW-1:0] timer_q, timer_d;
    logic             flag_q, flag_d;
    logic             capture;

    assign btn_raw     = {btn_prev_i, btn_next_i};
    assign aes_ready_o = ~hold_i;
    assign capture     = aes_valid_i & ~hold_i;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            stable_d[i] = stable_q[i];
            cnt_d[i]    = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == DbMax) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Capture beats buttons, buttons beat the auto tick; any button activity restarts the timer.
    always_comb begin
        data_d  = data_q;
        page_d  = page_q;
        timer_d = timer_q;
        flag_d  = flag_q;
        if (capture) begin
            data_d  = aes_data_i;
            page_d  = 2'd0;
            timer_d = '0;
            flag_d  = 1'b1;
        end else if (pulse_q != 2'b00) begin
            timer_d = '0;
            flag_d  = 1'b0;
            if (pulse_q == 2'b01) begin
                page_d = page_q + 2'd1;
            end else if (pulse_q == 2'b10) begin
                page_d = page_q - 2'd1;
            end
        end else if (!auto_en_i) begin
            timer_d = '0;
        end else if (timer_q == AutoMax) begin
            timer_d = '0;
            page_d  = page_q + 2'd1;
        end else begin
            timer_d = timer_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            stable_q     <= '0;
            stable_dly_q <= '0;
            pulse_q      <= '0;
            for (int i = 0; i < 2; i++) begin
                cnt_q[i] <= '0;
            end
            data_q  <= '0;
            page_q  <= '0;
            timer_q <= '0;
            flag_q  <= 1'b0;
        end else begin
            sync1_q      <= btn_raw;
            sync2_q      <= sync1_q;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            pulse_q      <= stable_q & ~stable_dly_q;
            for (int i = 0; i < 2; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            data_q  <= data_d;
            page_q  <= page_d;
            timer_q <= timer_d;
            flag_q  <= flag_d;
        end
    end

    assign disp_data_o = data_q;
    assign digit_sel_o = {1'b0, page_q};
    assign page_led_o  = 4'b0001 << page_q;
    assign new_flag_o  = flag_q;

endmodule

// File: tb/tb_display_page_sequencer.sv
// Bench for display_page_sequencer: a window-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_display_page_sequencer;

    localparam int unsigned D = 4;
    localparam int unsigned A = 16;

    localparam logic [127:0] K0 = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    localparam logic [127:0] K1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] K2 = 128'hA5A5A5A5_5A5A5A5A_F0F0F0F0_0F0F0F0F;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         aes_valid = 1'b0;
    logic [127:0] aes_data = '0;
    logic         aes_ready;
    logic         hold = 1'b0;
    logic         btn_next = 1'b0;
    logic         btn_prev = 1'b0;
    logic         auto_en = 1'b0;
    logic [127:0] disp_data;
    logic [2:0]   digit_sel;
    logic [3:0]   page_led;
    logic         new_flag;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    display_page_sequencer #(
        .DEBOUNCE_CYCLES(D),
        .AUTO_CYCLES    (A)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .aes_valid_i(aes_valid),
        .aes_data_i (aes_data),
        .aes_ready_o(aes_ready),
        .hold_i     (hold),
        .btn_next_i (btn_next),
        .btn_prev_i (btn_prev),
        .auto_en_i  (auto_en),
        .disp_data_o(disp_data),
        .digit_sel_o(digit_sel),
        .page_led_o (page_led),
        .new_flag_o (new_flag)
    );

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: a button level is accepted once the synchronized level (raw delayed two
    // edges) has disagreed with the accepted level on each of the last D edges since the
    // previous acceptance; a rising acceptance moves the page two edges later.
    logic [D:0]   hn, hp;
    bit           sn, sp;
    int           sfn, sfp;
    logic [1:0]   pn, pp;
    logic [127:0] m_data;
    int           m_page;
    bit           m_flag;
    int           m_run;

    function automatic bit differs(input logic [D:0] h, input bit st);
        for (int j = 1; j <= int'(D); j++) begin
            if (h[j] == st) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic m_reset();
        hn = '0; hp = '0; sn = 0; sp = 0; sfn = D; sfp = D; pn = '0; pp = '0;
        m_data = '0; m_page = 0; m_flag = 0; m_run = 0;
    endtask

    task automatic m_step();
        bit rn, rp, un, up, cap;
        rn = 0;
        rp = 0;
        sfn++;
        sfp++;
        if (sfn >= int'(D) && differs(hn, sn)) begin rn = !sn; sn = !sn; sfn = 0; end
        if (sfp >= int'(D) && differs(hp, sp)) begin rp = !sp; sp = !sp; sfp = 0; end
        hn = {hn[D-1:0], btn_next};
        hp = {hp[D-1:0], btn_prev};
        un = pn[1]; pn = {pn[0], rn};
        up = pp[1]; pp = {pp[0], rp};
        cap = aes_valid && !hold;
        if (cap) begin
            m_data = aes_data; m_page = 0; m_run = 0; m_flag = 1;
        end else if (un || up) begin
            if (un && !up) m_page = (m_page + 1) % 4;
            if (up && !un) m_page = (m_page + 3) % 4;
            m_run = 0;
            m_flag = 0;
        end else if (!auto_en) begin
            m_run = 0;
        end else begin
            m_run++;
            if (m_run == int'(A)) begin
                m_page = (m_page + 1) % 4;
                m_run = 0;
            end
        end
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) m_reset();
            else m_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("model_data", disp_data, m_data);
            chk("model_sel", 128'(digit_sel), 128'(m_page));
            chk("model_led", 128'(page_led), 128'(1 << m_page));
            chk("model_flag", 128'(new_flag), 128'(m_flag));
            chk("model_ready", 128'(aes_ready), 128'(!hold));
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic press(input bit nx, input bit pv);
        btn_next = nx;
        btn_prev = pv;
        cyc(12);
        btn_next = 0;
        btn_prev = 0;
        cyc(10);
    endtask

    task automatic capture(input logic [127:0] d);
        aes_data = d;
        aes_valid = 1;
        cyc(1);
        aes_valid = 0;
    endtask

    initial begin
        cyc(2);
        rst_n = 1;
        cyc(1);
        chk("rst_data", disp_data, 128'h0);
        chk("rst_sel", 128'(digit_sel), 128'd0);
        chk("rst_led", 128'(page_led), 128'h1);
        chk("rst_flag", 128'(new_flag), 128'd0);
        chk("rst_ready", 128'(aes_ready), 128'd1);

        btn_next = 1;
        cyc(3);
        btn_next = 0;
        cyc(10);
        chk("glitch_sel", 128'(digit_sel), 128'd0);

        capture(K0);
        chk("cap0_data", disp_data, K0);
        chk("cap0_flag", 128'(new_flag), 128'd1);

        btn_next = 1;
        cyc(7);
        chk("lat_edge7", 128'(digit_sel), 128'd0);
        cyc(1);
        chk("lat_edge8", 128'(digit_sel), 128'd1);
        chk("press_clears_flag", 128'(new_flag), 128'd0);
        cyc(12);
        btn_next = 0;
        cyc(10);
        chk("one_step", 128'(digit_sel), 128'd1);

        press(1, 0);
        chk("next_2", 128'(digit_sel), 128'd2);
        press(1, 0);
        chk("next_3", 128'(digit_sel), 128'd3);
        chk("led_3", 128'(page_led), 128'h8);
        press(1, 0);
        chk("wrap_0", 128'(digit_sel), 128'd0);
        press(0, 1);
        chk("prev_wrap_3", 128'(digit_sel), 128'd3);

        capture(K1);
        chk("cap_data", disp_data, K1);
        chk("cap_sel", 128'(digit_sel), 128'd0);
        chk("cap_flag", 128'(new_flag), 128'd1);

        hold = 1;
        aes_data = K2;
        aes_valid = 1;
        #1;
        chk("hold_ready", 128'(aes_ready), 128'd0);
        cyc(1);
        chk("hold_data", disp_data, K1);
        chk("hold_flag", 128'(new_flag), 128'd1);
        press(1, 0);
        chk("hold_btn_sel", 128'(digit_sel), 128'd1);
        chk("hold_btn_data", disp_data, K1);
        aes_valid = 0;
        hold = 0;

        capture(K0);
        press(1, 1);
        chk("both_sel0", 128'(digit_sel), 128'd0);
        chk("both_flag", 128'(new_flag), 128'd0);
        press(1, 0);
        press(1, 1);
        chk("both_sel1", 128'(digit_sel), 128'd1);

        btn_next = 1;
        cyc(7);
        aes_data = K2;
        aes_valid = 1;
        cyc(1);
        aes_valid = 0;
        chk("cap_vs_btn_sel", 128'(digit_sel), 128'd0);
        chk("cap_vs_btn_flag", 128'(new_flag), 128'd1);
        chk("cap_vs_btn_data", disp_data, K2);
        cyc(4);
        btn_next = 0;
        cyc(10);
        chk("cap_vs_btn_after", 128'(digit_sel), 128'd0);

        press(1, 0);
        press(1, 0);
        chk("pre_rst_sel", 128'(digit_sel), 128'd2);
        btn_next = 1;
        cyc(3);
        rst_n = 0;
        #1;
        chk("async_rst_data", disp_data, 128'h0);
        chk("async_rst_sel", 128'(digit_sel), 128'd0);
        chk("async_rst_led", 128'(page_led), 128'h1);
        chk("async_rst_flag", 128'(new_flag), 128'd0);
        btn_next = 0;
        cyc(2);
        rst_n = 1;
        btn_next = 1;
        cyc(7);
        chk("post_rst_edge7", 128'(digit_sel), 128'd0);
        cyc(1);
        chk("post_rst_edge8", 128'(digit_sel), 128'd1);
        cyc(4);
        btn_next = 0;
        cyc(10);

        capture(K1);
        auto_en = 1;
        cyc(15);
        chk("auto_15", 128'(digit_sel), 128'd0);
        cyc(1);
        chk("auto_16", 128'(digit_sel), 128'd1);
        cyc(16);
        chk("auto_32", 128'(digit_sel), 128'd2);
        cyc(8);
        btn_next = 1;
        cyc(7);
        chk("auto_btn_47", 128'(digit_sel), 128'd2);
        cyc(1);
        chk("auto_btn_48", 128'(digit_sel), 128'd3);
        cyc(4);
        btn_next = 0;
        cyc(11);
        chk("auto_63", 128'(digit_sel), 128'd3);
        cyc(1);
        chk("auto_64", 128'(digit_sel), 128'd0);
        auto_en = 0;
        cyc(40);
        chk("auto_off", 128'(digit_sel), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
